mainfsm: RTL

Multicycle control sequencer for the processor's control unit. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the datapath multiplexer selects. It also produces the unconditioned write requests (NextPC, RegW, MemW, Branch) that the condition logic gates with the instruction's condition result. Memory accesses wait on a MemReady handshake, so the block tolerates multi-cycle memory.

---
 rtl/mainfsm.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/mainfsm.sv
// mainfsm: multicycle control sequencer for the processor control unit.
// Walks each instruction through fetch, decode, execute, memory and
// writeback, drives the datapath mux selects and raises the
// unconditioned write requests that the condition logic later gates.
// Memory accesses hold in place until MemReady.
//
// Optional feature macro: MAINFSM_TRAP_EN
//   defined   : Op=11 enters TRAP, which raises Illegal and holds until reset
//   undefined : Op=11 returns to FETCH (two-cycle no-op), Illegal tied low
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset, forces FETCH
//   Op         in   [1:0] instruction class (00 DP, 01 mem, 10 branch, 11 undef)
//   Funct      in   [5:0] Funct[5] immediate flag, Funct[0] load/store
//   MemReady   in   memory completes the current access this cycle
//   IRWrite    out  load instruction register
//   AdrSrc     out  0 PC address, 1 computed data address
//   ALUSrcA    out  [1:0] 00 reg A, 01 PC, 10 old ALU result
//   ALUSrcB    out  [1:0] 00 reg B, 01 ext immediate, 10 constant 4
//   ResultSrc  out  [1:0] 00 ALUOut, 01 Data, 10 ALUResult
//   ALUOp      out  1 = ALU decoder uses Funct, 0 = add
//   NextPC     out  unconditional PC write request
//   RegW       out  register write request (ungated)
//   MemW       out  memory write request (ungated)
//   Branch     out  branch PC write request (ungated)
//   Illegal    out  undefined opcode detected
//
// Outputs are a pure decode of the state register (plus MemReady in FETCH),
// so an asynchronous reset drops MemW/RegW immediately without waiting for
// an edge.

module mainfsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       Illegal
);

  localparam int unsigned STATE_W = 4;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // Mux select encodings
  localparam logic [1:0] SRCA_REG  = 2'b00;
  localparam logic [1:0] SRCA_PC   = 2'b01;
  localparam logic [1:0] SRCA_OLD  = 2'b10;
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
`ifdef MAINFSM_TRAP_EN
    ,
    TRAP     = 4'd10
`endif
  } state_t;

  state_t state;
  state_t next_state;

  // Only Funct[5] and Funct[0] steer the sequence; the rest belongs to the ALU decoder.
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; unencoded state values fall back to FETCH
  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH: begin
        next_state = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        case (Op)
          OP_MEM:  next_state = MEMADR;
          OP_DP:   next_state = Funct[5] ? EXECUTEI : EXECUTER;
          OP_BR:   next_state = BRANCH;
`ifdef MAINFSM_TRAP_EN
          default: next_state = TRAP;
`else
          default: next_state = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        next_state = Funct[0] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        next_state = MemReady ? MEMWB : MEMREAD;
      end
      MEMWRITE: begin
        next_state = MemReady ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        next_state = ALUWB;
      end
      EXECUTEI: begin
        next_state = ALUWB;
      end
      MEMWB: begin
        next_state = FETCH;
      end
      ALUWB: begin
        next_state = FETCH;
      end
      BRANCH: begin
        next_state = FETCH;
      end
`ifdef MAINFSM_TRAP_EN
      TRAP: begin
        next_state = TRAP;
      end
`endif
      default: begin
        next_state = FETCH;
      end
    endcase
  end

  // Moore output decode; everything not named for a state stays low
  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = SRCA_REG;
    ALUSrcB   = SRCB_REG;
    ResultSrc = RES_ALUOUT;
    ALUOp     = 1'b0;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    Illegal   = 1'b0;
    case (state)
      FETCH: begin
        // PC+4 computed every fetch cycle; IR/PC only commit when memory answers
        AdrSrc    = 1'b0;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        IRWrite   = MemReady;
        NextPC    = MemReady;
      end
      DECODE: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
      end
      MEMADR: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_IMM;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegW      = 1'b1;
      end
      MEMWRITE: begin
        // Held for every waiting cycle so the memory sees a stable request
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_REG;
        ALUOp   = 1'b1;
      end
      EXECUTEI: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_IMM;
        ALUOp   = 1'b1;
      end
      ALUWB: begin
        RegW = 1'b1;
      end
      BRANCH: begin
        ALUSrcA   = SRCA_OLD;
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURES;
        Branch    = 1'b1;
      end
`ifdef MAINFSM_TRAP_EN
      TRAP: begin
        Illegal = 1'b1;
      end
`endif
      default: begin
        Illegal = 1'b0;
      end
    endcase
  end

endmodule
